// File: rtl/echo_sel_ctrl.sv
// Selection sequencer for signal_selector: echo input changes land only on frame
// boundaries of the selector output, from host requests, auto-cycling, or a stall timeout.
module echo_sel_ctrl #(
    parameter logic [1:0]  RESET_SEL      = 2'b00,
    parameter int unsigned AUTO_FRAMES    = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                 pi_clk,
    input  logic                 pi_rst,
    input  logic [1:0]           pi_sel_req,
    input  logic                 pi_sel_req_valid,
    output logic                 po_sel_req_ready,
    input  logic                 pi_auto_en,
    input  logic                 pi_mon_tvalid,
    input  logic                 pi_mon_tready,
    input  logic                 pi_mon_tlast,
    output logic [1:0]           po_echo_input_sel,
    output logic                 po_sel_ack,
    output logic                 po_timeout,
    output logic                 po_busy,
    output logic [CNT_WIDTH-1:0] po_frame_cnt
);

    localparam int unsigned STEP_W  = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned STALL_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [STEP_W-1:0]    STEP_LAST  = STEP_W'(AUTO_FRAMES - 1);
    localparam logic [STEP_W-1:0]    STEP_ONE   = STEP_W'(1);
    localparam logic [STALL_W-1:0]   STALL_LAST = STALL_W'(STALL_LAST_I);
    localparam logic [STALL_W-1:0]   STALL_ONE  = STALL_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [1:0]             sel;
    logic [1:0]             pend_sel;
    logic                   in_frame;
    logic                   forced;
    logic [STALL_W-1:0]     stall_cnt;
    logic [STEP_W-1:0]      step_cnt;
    logic [CNT_WIDTH-1:0]   frame_cnt;

    logic beat;
    logic boundary;
    logic host_take;
    logic auto_fire;
    logic switch_now;
    logic force_now;

    // Band sweep order dry -> high -> mid -> low -> dry.
    function automatic logic [1:0] next_sel(input logic [1:0] cur);
        return cur + 2'd1;
    endfunction

    assign beat     = pi_mon_tvalid & pi_mon_tready;
    assign boundary = beat & pi_mon_tlast;

    assign host_take  = (state == IDLE) & ~pi_auto_en & pi_sel_req_valid;
    assign auto_fire  = (state == IDLE) & pi_auto_en & boundary & (step_cnt == STEP_LAST);
    // A quiet cycle outside a frame is as safe as a boundary; a fresh non-last beat is not.
    assign switch_now = (state == PENDING) & (boundary | (~in_frame & ~beat));
    assign force_now  = (state == PENDING) & ~switch_now & ~beat & TIMEOUT_EN
                        & (stall_cnt == STALL_LAST);

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (host_take | auto_fire) state_next = PENDING;
            PENDING: if (switch_now | force_now) state_next = APPLY;
            APPLY:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        po_sel_req_ready = 1'b0;
        po_sel_ack       = 1'b0;
        po_timeout       = 1'b0;
        po_busy          = 1'b1;
        unique case (state)
            IDLE: begin
                po_sel_req_ready = ~pi_auto_en;
                po_busy          = 1'b0;
            end
            APPLY: begin
                po_sel_ack = 1'b1;
                po_timeout = forced;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            sel       <= RESET_SEL;
            pend_sel  <= RESET_SEL;
            in_frame  <= 1'b0;
            forced    <= 1'b0;
            stall_cnt <= '0;
            step_cnt  <= '0;
            frame_cnt <= '0;
        end else begin
            if (boundary) begin
                frame_cnt <= frame_cnt + CNT_ONE;
            end

            if (force_now | boundary) begin
                in_frame <= 1'b0;
            end else if (beat) begin
                in_frame <= 1'b1;
            end

            if (host_take) begin
                pend_sel <= pi_sel_req;
            end else if (auto_fire) begin
                pend_sel <= next_sel(sel);
            end

            if (state == IDLE) begin
                stall_cnt <= '0;
            end else if (state == PENDING) begin
                stall_cnt <= beat ? '0 : stall_cnt + STALL_ONE;
            end

            if (switch_now | force_now) begin
                sel <= pend_sel;
            end
            forced <= force_now;

            // Only boundaries seen while idle count toward the next auto step.
            if (!pi_auto_en) begin
                step_cnt <= '0;
            end else if ((state == IDLE) && boundary) begin
                step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + STEP_ONE;
            end
        end
    end

    assign po_echo_input_sel = sel;
    assign po_frame_cnt      = frame_cnt;

endmodule

// File: tb/tb_echo_sel_ctrl.sv
// Bench for echo_sel_ctrl: directed scenarios plus random traffic against a
// cycle-level reference model, with a scoreboard of predicted acknowledge events.
module tb_echo_sel_ctrl;

    localparam int         CW   = 4;
    localparam int         AF   = 2;
    localparam int         TO   = 16;
    localparam logic [1:0] RSEL = 2'b00;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    sel_req = 2'b00;
    logic          sel_req_valid = 1'b0;
    logic          sel_req_ready;
    logic          auto_en = 1'b0;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          mon_tlast = 1'b0;
    logic [1:0]    echo_sel;
    logic          sel_ack;
    logic          timeout_p;
    logic          busy;
    logic [CW-1:0] frame_cnt;

    echo_sel_ctrl #(
        .RESET_SEL(RSEL), .AUTO_FRAMES(AF), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
    ) dut (
        .pi_clk(clk), .pi_rst(rst),
        .pi_sel_req(sel_req), .pi_sel_req_valid(sel_req_valid), .po_sel_req_ready(sel_req_ready),
        .pi_auto_en(auto_en),
        .pi_mon_tvalid(mon_tvalid), .pi_mon_tready(mon_tready), .pi_mon_tlast(mon_tlast),
        .po_echo_input_sel(echo_sel), .po_sel_ack(sel_ack), .po_timeout(timeout_p),
        .po_busy(busy), .po_frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        int cyc;
        int sel;
        int to;
    } ack_t;
    ack_t exp_q[$];

    // Reference model: a request is "waiting" until it may be applied; an applied
    // request produces exactly one ack cycle, after which the next request is accepted.
    int cyc       = 0;
    int m_sel     = RSEL;
    int m_target  = 0;
    int m_frames  = 0;
    int m_steps   = 0;
    int m_quiet   = 0;
    bit m_waiting = 0;
    bit m_ack_now = 0;
    bit m_in_frame = 0;

    function automatic void expect_ack(int s, int to);
        ack_t e;
        e.cyc = cyc;
        e.sel = s;
        e.to  = to;
        exp_q.push_back(e);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_sel = RSEL; m_waiting = 0; m_ack_now = 0; m_in_frame = 0;
            m_quiet = 0; m_frames = 0; m_steps = 0;
            exp_q.delete();
        end else begin
            bit beat, bnd, was_ack, kill;
            cyc++;
            beat    = mon_tvalid && mon_tready;
            bnd     = beat && mon_tlast;
            was_ack = m_ack_now;
            kill    = 0;
            m_ack_now = 0;
            if (m_waiting) begin
                if (bnd || (!m_in_frame && !beat)) begin
                    m_sel = m_target; m_waiting = 0; m_ack_now = 1;
                    expect_ack(m_target, 0);
                end else if (beat) begin
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (TO != 0 && m_quiet == TO) begin
                        m_sel = m_target; m_waiting = 0; m_ack_now = 1; kill = 1;
                        expect_ack(m_target, 1);
                    end
                end
            end else if (!was_ack) begin
                if (!auto_en && sel_req_valid) begin
                    m_target = int'(sel_req); m_waiting = 1; m_quiet = 0;
                end else if (auto_en && bnd) begin
                    m_steps++;
                    if (m_steps == AF) begin
                        m_steps = 0; m_target = (m_sel + 1) % 4; m_waiting = 1; m_quiet = 0;
                    end
                end
            end
            if (!auto_en) m_steps = 0;
            if (bnd) m_frames = (m_frames + 1) % (1 << CW);
            if (kill || bnd) m_in_frame = 0;
            else if (beat) m_in_frame = 1;
        end
    end

    // Monitor: continuous outputs every cycle, ack events against the scoreboard.
    always @(negedge clk) begin
        ack_t e;
        chk("sel", int'(echo_sel), m_sel);
        chk("frame_cnt", int'(frame_cnt), m_frames);
        chk("busy", int'(busy), int'(m_waiting || m_ack_now));
        chk("ready", int'(sel_req_ready), int'(!m_waiting && !m_ack_now && !auto_en));
        if (sel_ack) begin
            if (exp_q.size() == 0) begin
                chk("ack_spurious", int'(sel_ack), 0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_cycle", cyc, e.cyc);
                chk("ack_sel", int'(echo_sel), e.sel);
                chk("ack_timeout", int'(timeout_p), e.to);
            end
        end else begin
            chk("timeout_without_ack", int'(timeout_p), 0);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("ack_late", cyc, e.cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input logic [1:0] s);
        sel_req = s; sel_req_valid = 1'b1;
        tick();
        sel_req_valid = 1'b0;
    endtask

    int stall_left = 0;

    initial begin
        mon_tready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_sel", int'(echo_sel), int'(RSEL));
        chk("reset_ready", int'(sel_req_ready), 1);
        chk("reset_frame_cnt", int'(frame_cnt), 0);

        // Idle stream: switch lands two cycles after the request
        req(2'b01);
        tick();
        chk("t1_sel", int'(echo_sel), 1);
        chk("t1_ack", int'(sel_ack), 1);
        tick();
        chk("t1_ack_once", int'(sel_ack), 0);
        chk("t1_busy", int'(busy), 0);

        // Request during beat 3 of an 8-beat frame waits for tlast
        for (int i = 0; i < 8; i++) begin
            mon_tvalid = 1'b1; mon_tlast = (i == 7);
            if (i == 3) begin sel_req = 2'b10; sel_req_valid = 1'b1; end
            else sel_req_valid = 1'b0;
            tick();
            if (i >= 4 && i < 7) chk("t2_hold", int'(echo_sel), 1);
        end
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        chk("t2_sel", int'(echo_sel), 2);
        chk("t2_ack", int'(sel_ack), 1);
        tick();

        // Stream dies mid-frame: forced switch after TO quiet cycles
        for (int i = 0; i < 2; i++) begin
            mon_tvalid = 1'b1; tick();
        end
        mon_tvalid = 1'b0;
        req(2'b11);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("t3_hold", int'(echo_sel), 2);
        end
        tick();
        chk("t3_sel", int'(echo_sel), 3);
        chk("t3_ack", int'(sel_ack), 1);
        chk("t3_timeout", int'(timeout_p), 1);
        tick();
        req(2'b00);
        tick();
        chk("t3_frame_cleared", int'(echo_sel), 0);
        tick();

        // Auto-cycle: every AF-th single-beat frame steps the band
        auto_en = 1'b1;
        for (int f = 1; f <= 8; f++) begin
            mon_tvalid = 1'b1; mon_tlast = 1'b1;
            tick();
            mon_tvalid = 1'b0; mon_tlast = 1'b0;
            repeat (3) tick();
            chk("t4_ready_blocked", int'(sel_req_ready), 0);
            if (f % AF == 0) chk("t4_sel", int'(echo_sel), (f / AF) % 4);
        end
        auto_en = 1'b0;
        tick();

        // Reset while a request is pending
        req(2'b10);
        repeat (2) tick();
        mon_tvalid = 1'b1; mon_tlast = 1'b0;
        req(2'b01);
        mon_tvalid = 1'b0;
        repeat (3) tick();
        chk("t5_pending", int'(busy), 1);
        rst = 1'b1;
        tick();
        chk("t5_sel", int'(echo_sel), int'(RSEL));
        chk("t5_frame_cnt", int'(frame_cnt), 0);
        chk("t5_no_ack", int'(sel_ack), 0);
        rst = 1'b0;
        tick();
        chk("t5_ready", int'(sel_req_ready), 1);
        repeat (3) tick();
        chk("t5_sel_kept", int'(echo_sel), int'(RSEL));

        // Same-value request still acknowledges; three frames counted
        req(2'b00);
        tick();
        chk("t6_ack", int'(sel_ack), 1);
        chk("t6_sel", int'(echo_sel), 0);
        for (int f = 0; f < 3; f++) begin
            mon_tvalid = 1'b1; mon_tlast = 1'b0; tick();
            mon_tlast = 1'b1; tick();
        end
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        tick();
        chk("t6_frame_cnt", int'(frame_cnt), 3);

        // Random traffic with occasional long stalls, mode flips and resets
        for (int c = 0; c < 3000; c++) begin
            mon_tready = ($urandom_range(0, 3) != 0);
            mon_tlast  = ($urandom_range(0, 3) == 0);
            if (stall_left > 0) begin
                mon_tvalid = 1'b0;
                stall_left--;
            end else begin
                mon_tvalid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 60) == 0) stall_left = $urandom_range(10, 25);
            end
            sel_req       = 2'($urandom_range(0, 3));
            sel_req_valid = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            tick();
        end

        mon_tvalid = 1'b0; mon_tlast = 1'b0; sel_req_valid = 1'b0; auto_en = 1'b0;
        repeat (40) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
